hist_sequencer: RTL and testbench

HIST_SEQUENCER -- requirements
Module: hist_sequencer

---
 rtl/measurement_pkg.sv | 30 +++
 rtl/hist_sequencer_if.sv | 31 +++
 rtl/readout_tracker.sv | 63 ++++++
 rtl/hist_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_hist_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/measurement_pkg.sv
// Shared types for the measurement sequencer: FSM state encoding, 64-bit
// timestamps and the saturating time adder.
package measurement_pkg;

  typedef logic [63:0] time_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONFIG   = 3'd1,
    CLEAR    = 3'd2,
    ARM      = 3'd3,
    ACQUIRE  = 3'd4,
    READ_REQ = 3'd5,
    READOUT  = 3'd6,
    NEXT     = 3'd7
  } seq_state_e;

  localparam time_t TIME_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic time_t sat_add(input time_t a, input time_t b);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[64]) begin
      sat_add = TIME_MAX;
    end else begin
      sat_add = sum[63:0];
    end
  endfunction

endpackage

// File: rtl/hist_sequencer_if.sv
// Histogram control/readout bus plus the forwarded readout stream.
interface hist_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  hist_config_en_o;
  logic                  hist_reset_o;
  logic                  hist_read_start_o;
  logic [5:0]            hist_click_channel_o;
  logic [5:0]            hist_start_channel_o;
  logic [4:0]            hist_shift_val_o;
  logic [DATA_WIDTH-1:0] hist_data_i;
  logic                  hist_valid_i;
  logic                  m_tvalid;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tlast;
  logic [15:0]           m_tuser;

  modport master (
    output hist_config_en_o, hist_reset_o, hist_read_start_o,
    output hist_click_channel_o, hist_start_channel_o, hist_shift_val_o,
    input  hist_data_i, hist_valid_i,
    output m_tvalid, m_tdata, m_tlast, m_tuser
  );

  modport slave (
    input  hist_config_en_o, hist_reset_o, hist_read_start_o,
    input  hist_click_channel_o, hist_start_channel_o, hist_shift_val_o,
    output hist_data_i, hist_valid_i,
    input  m_tvalid, m_tdata, m_tlast, m_tuser
  );
endinterface

// File: rtl/readout_tracker.sv
// Acquisition end-time capture (saturating) and readout beat / idle-timeout
// counting for the histogram sequencer.
module readout_tracker
  import measurement_pkg::*;
#(
  parameter int NUM_BINS     = 4096,
  parameter int READ_TIMEOUT = 65535
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  arm,
  input  time_t time_now,
  input  time_t window,
  output logic  acq_done,
  input  logic  clear,
  input  logic  active,
  input  logic  beat,
  output logic  beat_last,
  output logic  timed_out
);
  localparam int BW = $clog2(NUM_BINS + 1);
  localparam int TW = $clog2(READ_TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BINS - 1);
  localparam logic [TW-1:0] IDLE_ONE  = TW'(1);
  localparam logic [TW-1:0] LAST_IDLE = TW'(READ_TIMEOUT - 1);

  time_t         t_end_r;
  logic [BW-1:0] beat_cnt_r;
  logic [TW-1:0] idle_cnt_r;

  // End-of-window timestamp, captured once per run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_end_r <= '0;
    end else if (arm) begin
      t_end_r <= sat_add(time_now, window);
    end
  end

  // Beat count and cycles since the last beat; both restart per read request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= '0;
      idle_cnt_r <= '0;
    end else if (clear) begin
      beat_cnt_r <= '0;
      idle_cnt_r <= '0;
    end else if (active) begin
      if (beat) begin
        beat_cnt_r <= beat_cnt_r + BEAT_ONE;
        idle_cnt_r <= '0;
      end else begin
        idle_cnt_r <= idle_cnt_r + IDLE_ONE;
      end
    end
  end

  assign acq_done  = (time_now >= t_end_r);
  assign beat_last = active && beat && (beat_cnt_r == LAST_BEAT);
  assign timed_out = active && !beat && (idle_cnt_r == LAST_IDLE);

endmodule

// File: rtl/hist_sequencer.sv
// Sequences histogram configure / clear / acquire / readout over a number of
// runs and forwards the readout beats as a stream tagged with the run index.
module hist_sequencer
  import measurement_pkg::*;
#(
  parameter int NUM_BINS     = 4096,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [5:0]              cfg_click_channel,
  input  logic [5:0]              cfg_start_channel,
  input  logic [4:0]              cfg_shift_val,
  input  time_t                   cfg_window,
  input  logic [15:0]             cfg_num_runs,
  input  time_t                   lowest_time_bound,
  hist_sequencer_if.master        hist_bus,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err
);
  logic [1:0]            rst_sync_r;
  logic                  rst_n_s;
  seq_state_e            state_r, state_nxt_s;
  logic                  start_ok_s, abort_hit_s, last_run_s, rd_beat_s;
  logic                  done_s, timeout_hit_s;
  logic                  acq_done_s, beat_last_s, timed_out_s;
  time_t                 window_r;
  logic [15:0]           num_runs_r, run_idx_r;
  logic [5:0]            click_ch_r, start_ch_r;
  logic [4:0]            shift_r;
  logic                  busy_r, done_r, timeout_err_r;
  logic                  config_en_r, hreset_r, read_start_r;
  logic                  m_tvalid_r, m_tlast_r;
  logic [DATA_WIDTH-1:0] m_tdata_r;
  logic [15:0]           m_tuser_r;

  // Reset asserts immediately, releases two clock edges later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_r[1];

  assign start_ok_s  = (state_r == IDLE) && start && !abort;
  assign abort_hit_s = abort && (state_r != IDLE);
  assign last_run_s  = ({1'b0, run_idx_r} + 17'd1) >= {1'b0, num_runs_r};
  assign rd_beat_s   = (state_r == READOUT) && hist_bus.hist_valid_i;

  readout_tracker #(.NUM_BINS(NUM_BINS), .READ_TIMEOUT(READ_TIMEOUT)) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n_s),
    .arm       (state_r == ARM),
    .time_now  (lowest_time_bound),
    .window    (window_r),
    .acq_done  (acq_done_s),
    .clear     (state_r == READ_REQ),
    .active    (state_r == READOUT),
    .beat      (hist_bus.hist_valid_i),
    .beat_last (beat_last_s),
    .timed_out (timed_out_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; abort overrides every other transition
  always_comb begin
    state_nxt_s   = state_r;
    done_s        = 1'b0;
    timeout_hit_s = 1'b0;
    if (abort_hit_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:     if (start_ok_s) state_nxt_s = CONFIG; else state_nxt_s = IDLE;
        CONFIG:   state_nxt_s = CLEAR;
        CLEAR:    state_nxt_s = ARM;
        ARM:      state_nxt_s = ACQUIRE;
        ACQUIRE:  if (acq_done_s) state_nxt_s = READ_REQ; else state_nxt_s = ACQUIRE;
        READ_REQ: state_nxt_s = READOUT;
        READOUT: begin
          if (timed_out_s) begin
            state_nxt_s   = IDLE;
            done_s        = 1'b1;
            timeout_hit_s = 1'b1;
          end else if (beat_last_s) begin
            state_nxt_s = NEXT;
          end else begin
            state_nxt_s = READOUT;
          end
        end
        NEXT: begin
          if (last_run_s) begin
            state_nxt_s = IDLE;
            done_s      = 1'b1;
          end else begin
            state_nxt_s = CLEAR;
          end
        end
        default:  state_nxt_s = IDLE;
      endcase
    end
  end

  // Control pulses and status, aligned with the state they belong to
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      config_en_r   <= 1'b0;
      hreset_r      <= 1'b0;
      read_start_r  <= 1'b0;
    end else begin
      busy_r       <= (state_nxt_s != IDLE);
      done_r       <= done_s;
      config_en_r  <= (state_nxt_s == CONFIG);
      hreset_r     <= (state_nxt_s == CLEAR) || abort_hit_s;
      read_start_r <= (state_nxt_s == READ_REQ);
      if (start_ok_s) begin
        timeout_err_r <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  // Configuration snapshot taken at start, plus the run index
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      click_ch_r <= 6'd0;
      start_ch_r <= 6'd0;
      shift_r    <= 5'd0;
      window_r   <= '0;
      num_runs_r <= 16'd0;
      run_idx_r  <= 16'd0;
    end else if (start_ok_s) begin
      click_ch_r <= cfg_click_channel;
      start_ch_r <= cfg_start_channel;
      shift_r    <= cfg_shift_val;
      window_r   <= cfg_window;
      num_runs_r <= (cfg_num_runs == 16'd0) ? 16'd1 : cfg_num_runs;
      run_idx_r  <= 16'd0;
    end else if ((state_r == NEXT) && !abort_hit_s) begin
      run_idx_r <= run_idx_r + 16'd1;
    end
  end

  // Readout stream, one cycle behind the histogram beats
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tdata_r  <= '0;
      m_tuser_r  <= 16'd0;
    end else begin
      m_tvalid_r <= rd_beat_s && !abort_hit_s;
      m_tlast_r  <= beat_last_s && !abort_hit_s;
      if (rd_beat_s) begin
        m_tdata_r <= hist_bus.hist_data_i;
        m_tuser_r <= run_idx_r;
      end
    end
  end

  assign hist_bus.hist_config_en_o     = config_en_r;
  assign hist_bus.hist_reset_o         = hreset_r;
  assign hist_bus.hist_read_start_o    = read_start_r;
  assign hist_bus.hist_click_channel_o = click_ch_r;
  assign hist_bus.hist_start_channel_o = start_ch_r;
  assign hist_bus.hist_shift_val_o     = shift_r;
  assign hist_bus.m_tvalid             = m_tvalid_r;
  assign hist_bus.m_tdata              = m_tdata_r;
  assign hist_bus.m_tlast              = m_tlast_r;
  assign hist_bus.m_tuser              = m_tuser_r;
  assign busy                          = busy_r;
  assign done                          = done_r;
  assign timeout_err                   = timeout_err_r;

endmodule

// File: tb/tb_hist_sequencer.sv
// Directed bench for hist_sequencer with a small histogram model and a
// scoreboard of expected readout beats.
module tb_hist_sequencer;
  import measurement_pkg::*;

  localparam int NB = 8;
  localparam int DW = 32;
  localparam int RT = 16;
  localparam time_t TMAX = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [5:0]  cfg_click_channel, cfg_start_channel;
  logic [4:0]  cfg_shift_val;
  time_t       cfg_window, ltb;
  logic [15:0] cfg_num_runs;
  logic        busy, done, timeout_err;

  hist_sequencer_if #(.DATA_WIDTH(DW)) hif();

  hist_sequencer #(.NUM_BINS(NB), .DATA_WIDTH(DW), .READ_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_click_channel(cfg_click_channel), .cfg_start_channel(cfg_start_channel),
    .cfg_shift_val(cfg_shift_val), .cfg_window(cfg_window),
    .cfg_num_runs(cfg_num_runs), .lowest_time_bound(ltb),
    .hist_bus(hif), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int n_cfg, n_rst, n_rd, n_beats, n_last, n_done, last_at_done;
  int cyc_no = 0, rd_cyc, beats_per_read, beats_left, beat_no, stray_n;
  time_t step = 64'd0, rd_ltb;
  logic [15:0] rd_run;
  logic [48:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_cfg = 0; n_rst = 0; n_rd = 0; n_beats = 0; n_last = 0; n_done = 0;
    last_at_done = -1; rd_cyc = -1; beats_left = 0; beat_no = 0; stray_n = 0;
    rd_run = 16'd0; rd_ltb = 64'd0;
    sb_q.delete();
  endtask

  // One clock: drive inputs after the rising edge, observe at the falling edge
  task automatic cyc();
    logic [48:0] e;
    @(posedge clk); #1;
    cyc_no++;
    start = 1'b0; abort = 1'b0;
    if (ltb > TMAX - step) ltb = TMAX; else ltb = ltb + step;
    if (beats_left > 0) begin
      hif.hist_valid_i = 1'b1;
      hif.hist_data_i  = {8'hA5, rd_run[7:0], 8'h3C, beat_no[7:0]};
      sb_q.push_back({(beat_no == NB - 1), rd_run, hif.hist_data_i});
      beat_no++; beats_left--;
    end else if (stray_n > 0) begin
      hif.hist_valid_i = 1'b1;
      hif.hist_data_i  = 32'h5757_5757;
      stray_n--;
    end else begin
      hif.hist_valid_i = 1'b0;
      hif.hist_data_i  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    if (hif.hist_config_en_o) n_cfg++;
    if (hif.hist_reset_o) n_rst++;
    if (done) begin n_done++; last_at_done = n_last; end
    if (hif.hist_read_start_o) begin
      n_rd++; rd_run = 16'(n_rd - 1); rd_cyc = cyc_no; rd_ltb = ltb;
      beats_left = beats_per_read; beat_no = 0;
    end
    if (hif.m_tvalid) begin
      n_beats++;
      if (hif.m_tlast) n_last++;
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("beat_last_user_data", {15'd0, hif.m_tlast, hif.m_tuser, hif.m_tdata}, {15'd0, e});
      end
    end
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) cyc();
    check(tag, 64'(n_done > d0), 64'd1);
  endtask

  task automatic launch(input logic [15:0] runs, input time_t win, input int bpr);
    clear_counts();
    cfg_num_runs = runs; cfg_window = win; beats_per_read = bpr;
    start = 1'b1;
    cyc();
  endtask

  initial begin
    int c0, snap;
    rst = 1'b0; start = 1'b0; abort = 1'b0; ltb = 64'd0;
    cfg_click_channel = 6'h15; cfg_start_channel = 6'h2A; cfg_shift_val = 5'd7;
    cfg_window = 64'd1000; cfg_num_runs = 16'd1;
    hif.hist_valid_i = 1'b0; hif.hist_data_i = 32'd0;
    clear_counts(); beats_per_read = NB;

    // Reset state
    repeat (3) cyc();
    check("rst_status", {61'd0, busy, done, timeout_err}, 64'd0);
    check("rst_ctrl", {61'd0, hif.hist_config_en_o, hif.hist_reset_o, hif.hist_read_start_o}, 64'd0);
    check("rst_cfg_out", {47'd0, hif.hist_click_channel_o, hif.hist_start_channel_o, hif.hist_shift_val_o}, 64'd0);
    check("rst_stream", {46'd0, hif.m_tvalid, hif.m_tlast, hif.m_tuser}, 64'd0);

    // Start on the first edge after release is ignored
    rst = 1'b1; start = 1'b1;
    cyc();
    check("start_after_release", 64'(busy), 64'd0);
    repeat (3) cyc();

    // Single run, 8 bins, window 1000 at +100/cycle
    step = 64'd100; ltb = 64'd0;
    launch(16'd1, 64'd1000, NB);
    c0 = cyc_no;
    check("config_pulse", {62'd0, hif.hist_config_en_o, busy}, 64'd3);
    check("cfg_out", {47'd0, hif.hist_click_channel_o, hif.hist_start_channel_o, hif.hist_shift_val_o},
          {47'd0, 6'h15, 6'h2A, 5'd7});
    cfg_click_channel = 6'h01; cfg_start_channel = 6'h02; cfg_shift_val = 5'd3; cfg_num_runs = 16'd5;
    stray_n = 1;
    run_until_done(80, "run1_done");
    check("run1_busy_at_done", 64'(busy), 64'd0);
    check("run1_read_latency", 64'(rd_cyc - c0), 64'd13);
    check("run1_counts", {n_cfg[7:0], n_rst[7:0], n_rd[7:0], n_beats[7:0], n_last[7:0], n_done[7:0]},
          {8'd1, 8'd1, 8'd1, 8'd8, 8'd1, 8'd1});
    check("cfg_held", {47'd0, hif.hist_click_channel_o, hif.hist_start_channel_o, hif.hist_shift_val_o},
          {47'd0, 6'h15, 6'h2A, 5'd7});
    cyc();
    check("done_one_cycle", 64'(done), 64'd0);

    // Three runs
    launch(16'd3, 64'd300, NB);
    run_until_done(200, "runs3_done");
    check("runs3_counts", {n_cfg[7:0], n_rst[7:0], n_rd[7:0], n_beats[7:0], n_last[7:0], n_done[7:0]},
          {8'd1, 8'd3, 8'd3, 8'd24, 8'd3, 8'd1});
    check("runs3_done_after_last", 64'(last_at_done), 64'd3);
    check("runs3_no_timeout", 64'(timeout_err), 64'd0);

    // Abort during ACQUIRE of run 2
    launch(16'd3, 64'd1000, NB);
    for (int i = 0; i < 100 && n_rst < 2; i++) cyc();
    check("abort_reached_run2", 64'(n_rst), 64'd2);
    cyc(); cyc();
    snap = n_rst;
    abort = 1'b1;
    cyc();
    check("abort_idle", {62'd0, busy, hif.hist_reset_o}, 64'd1);
    repeat (20) cyc();
    check("abort_counts", {n_rst[7:0], n_done[7:0], n_beats[7:0], n_rd[7:0]},
          {8'(snap + 1), 8'd0, 8'd8, 8'd1});

    // Histogram stalls after 5 of 8 beats
    launch(16'd1, 64'd200, 5);
    for (int i = 0; i < 60 && n_beats < 5; i++) cyc();
    check("to_beats", 64'(n_beats), 64'd5);
    repeat (15) cyc();
    check("to_before", {62'd0, timeout_err, busy}, 64'd1);
    cyc();
    check("to_after", {61'd0, timeout_err, done, busy}, 64'd6);
    repeat (3) cyc();
    check("to_sticky_no_last", {32'd0, 8'(timeout_err), n_last[7:0], n_done[7:0], 8'd0}, {32'd0, 8'd1, 8'd0, 8'd1, 8'd0});

    // End-time saturation near the top of the time range
    step = 64'd1; ltb = TMAX - 64'd10;
    launch(16'd1, 64'd100, NB);
    check("sat_err_cleared", 64'(timeout_err), 64'd0);
    run_until_done(80, "sat_done");
    check("sat_read_at_max", rd_ltb, TMAX);
    check("sat_last", 64'(n_last), 64'd1);

    // start together with abort while idle
    clear_counts();
    start = 1'b1; abort = 1'b1;
    cyc();
    check("start_abort_idle", {62'd0, busy, hif.hist_config_en_o}, 64'd0);
    cyc();
    check("start_abort_idle2", {62'd0, busy, hif.hist_reset_o}, 64'd0);

    // Asynchronous reset mid-run
    step = 64'd100; ltb = 64'd0;
    launch(16'd2, 64'd1000, NB);
    repeat (3) cyc();
    check("midrun_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("midrun_rst_status", {61'd0, busy, done, timeout_err}, 64'd0);
    check("midrun_rst_cfg", {47'd0, hif.hist_click_channel_o, hif.hist_start_channel_o, hif.hist_shift_val_o}, 64'd0);
    repeat (2) cyc();
    rst = 1'b1;
    repeat (3) cyc();
    check("midrun_after_release", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
